// File: rtl/pdm2pcm_pkg.sv
// Shared types and constants for the PDM microphone front end.
package pdm2pcm_pkg;

   localparam int PDM_DIV_W           = 8;
   localparam int PDM_MIN_HALF_PERIOD = 4;

   typedef enum logic [1:0] {IDLE, WAKEUP, RUN} pdm_frontend_state_t;

   typedef struct packed {
      logic right;
      logic left;
   } pdm_channel_mode_t;

   // Half-period below the minimum cannot leave room for the pre-edge strobes.
   function automatic logic [PDM_DIV_W-1:0] clamp_half(input logic [PDM_DIV_W-1:0] div);
      return (div < PDM_DIV_W'(PDM_MIN_HALF_PERIOD)) ? PDM_DIV_W'(PDM_MIN_HALF_PERIOD) : div;
   endfunction

endpackage

// File: rtl/pdm2pcm_clock_generator.sv
// Divides clk_i down to the 50% duty microphone clock and flags the cycle
// before each rising and falling edge.
module pdm2pcm_clock_generator
   import pdm2pcm_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic [PDM_DIV_W-1:0] clock_divisor_i,
   output logic                 pdm_clk_o,
   output logic                 pre_rise_o,
   output logic                 pre_fall_o
);

   logic [PDM_DIV_W-1:0] r_cnt;
   logic [PDM_DIV_W-1:0] r_half;
   logic                 r_pdm_clk;
   logic                 w_wrap;

   assign w_wrap = en_i && (r_cnt == r_half - PDM_DIV_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt     <= '0;
         r_half    <= PDM_DIV_W'(PDM_MIN_HALF_PERIOD);
         r_pdm_clk <= 1'b0;
      end else if (!en_i) begin
         r_cnt     <= '0;
         r_pdm_clk <= 1'b0;
         r_half    <= clamp_half(clock_divisor_i);
      end else if (w_wrap) begin
         // Divisor is only picked up here so a half-period never changes length midway.
         r_cnt     <= '0;
         r_pdm_clk <= ~r_pdm_clk;
         r_half    <= clamp_half(clock_divisor_i);
      end else begin
         r_cnt     <= r_cnt + PDM_DIV_W'(1);
      end
   end

   assign pdm_clk_o  = r_pdm_clk;
   assign pre_rise_o = w_wrap && !r_pdm_clk;
   assign pre_fall_o = w_wrap &&  r_pdm_clk;

endmodule

// File: rtl/pdm2pcm_frontend.sv
// PDM microphone front end: clock generation, data synchronisation, wake-up
// suppression and per-channel sample strobes for the processing pipeline.
module pdm2pcm_frontend
   import pdm2pcm_pkg::*;
#(
   parameter int STARTUP_EDGES = 1024,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 clk_en_i,
   input  logic [PDM_DIV_W-1:0] clock_divisor_i,
   input  logic [1:0]           channel_mode_i,
   input  logic                 pdm_data_i,
   output logic                 pdm_clk_o,
   output logic                 pdm_o,
   output logic                 valid_o,
   output logic                 channel_o,
   output logic                 running_o
);

   localparam int STARTUP_W = $clog2(STARTUP_EDGES + 1);

   pdm_frontend_state_t  r_state;
   pdm_frontend_state_t  w_state_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [STARTUP_W-1:0] r_startup_cnt;
   logic                 r_pdm;
   logic                 r_valid;
   logic                 r_channel;
   logic                 w_gen_en;
   logic                 w_pre_rise;
   logic                 w_pre_fall;
   logic                 w_startup_done;
   logic                 w_take_left;
   logic                 w_take_right;
   pdm_channel_mode_t    w_mode;

   assign w_mode   = pdm_channel_mode_t'(channel_mode_i);
   assign w_gen_en = clk_en_i && (r_state != IDLE);

   pdm2pcm_clock_generator u_clock_generator (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .en_i            (w_gen_en),
      .clock_divisor_i (clock_divisor_i),
      .pdm_clk_o       (pdm_clk_o),
      .pre_rise_o      (w_pre_rise),
      .pre_fall_o      (w_pre_fall)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pdm_data_i};
      end
   end

   assign w_startup_done = (r_startup_cnt == STARTUP_W'(STARTUP_EDGES - 1));

   // NOTE: next-state gets a default before any branch so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      if (!clk_en_i) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_next = WAKEUP;
            WAKEUP:  if (w_pre_rise && w_startup_done) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state       <= IDLE;
         r_startup_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state != WAKEUP || !clk_en_i) begin
            r_startup_cnt <= '0;
         end else if (w_pre_rise) begin
            r_startup_cnt <= r_startup_cnt + STARTUP_W'(1);
         end
      end
   end

   // The edge that completes wake-up is still in WAKEUP, so it yields no left sample.
   assign w_take_left  = (r_state == RUN) && w_pre_rise && w_mode.left;
   assign w_take_right = (r_state == RUN) && w_pre_fall && w_mode.right;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pdm     <= 1'b0;
         r_valid   <= 1'b0;
         r_channel <= 1'b0;
      end else begin
         r_valid <= w_take_left || w_take_right;
         if (w_take_left || w_take_right) begin
            r_pdm     <= r_sync[SYNC_STAGES-1];
            r_channel <= w_take_right;
         end
      end
   end

   assign pdm_o     = r_pdm;
   assign valid_o   = r_valid;
   assign channel_o = r_channel;
   assign running_o = (r_state == RUN);

endmodule

// File: doc/pdm2pcm_frontend.md
Name: pdm2pcm_frontend

Overview:
Microphone-side front end of the PDM2PCM path.
- Generates the PDM microphone clock from the system clock.
- Synchronizes the incoming PDM data line.
- Samples left and right channels on opposite microphone-clock edges.
- Emits one single-cycle valid bit per sample, tagged with its channel. These outputs drive pdm_i, valid_i and channel_i of pdm2pcm_processing_pipeline.
- Suppresses samples during a microphone wake-up interval after enable.

Parameters:
STARTUP_EDGES, 1024, number of pdm_clk_o rising edges after enable during which samples are discarded (microphone settling).
SYNC_STAGES, 2, depth of the pdm_data_i synchronizer; legal values are 2 or more.

Ports:
clk_i  input  1  system clock; the block has a single clock domain.
rst_n_i  input  1  reset, asynchronous, active-low.
clk_en_i  input  1  block enable; low stops the microphone clock and returns the block to IDLE.
clock_divisor_i  input  8  half-period of pdm_clk_o, in clk_i cycles; values below 4 are clamped to 4.
channel_mode_i  input  2  bit0 enables left (channel 0), bit1 enables right (channel 1).
pdm_data_i  input  1  asynchronous PDM data from the microphone(s).
pdm_clk_o  output  1  microphone clock.
pdm_o  output  1  sampled PDM bit.
valid_o  output  1  single-cycle strobe qualifying pdm_o and channel_o.
channel_o  output  1  channel of the current sample: 0 = left, 1 = right.
running_o  output  1  high while in RUN.

Behaviour:
- Reset values: pdm_clk_o=0, pdm_o=0, valid_o=0, channel_o=0, running_o=0. FSM=IDLE, all counters 0, synchronizer flops 0.
- pdm_data_i always passes through SYNC_STAGES flops. The stored sample is the synchronizer output.

FSM states: IDLE, WAKEUP, RUN.
- IDLE: half-period counter held at 0, pdm_clk_o held low, no valid_o. When clk_en_i=1, go to WAKEUP on the next cycle.
- WAKEUP: clock runs. Count rising edges of pdm_clk_o. On the cycle that generates edge number STARTUP_EDGES, go to RUN.
- RUN: clock runs; samples are emitted. running_o=1.
- clk_en_i=0 in any state: go to IDLE next cycle. Counters and pdm_clk_o clear on that same cycle edge; any sample in flight is dropped (valid_o=0 next cycle).

Clock generation:
- half = max(clock_divisor_i, 4). This value is latched when the counter wraps (start of every half-period). A divisor change mid-half-period therefore takes effect at the next half-period.
- The counter counts 0..half-1. At half-1 it wraps to 0 and pdm_clk_o toggles on the next clk_i edge.
- Duty cycle is exactly 50%. Period = 2*half clk_i cycles.
- With the default divisor 4, pdm_clk_o = clk_i/8.

Sampling:
- Left sample: taken when the counter is at half-1 and pdm_clk_o=0, i.e. on the cycle before the rising edge.
- Right sample: taken when the counter is at half-1 and pdm_clk_o=1, i.e. before the falling edge.
- In RUN, if the corresponding channel_mode_i bit is set, the next cycle gives pdm_o = synchronizer output, valid_o=1 and channel_o = channel.
- valid_o therefore rises in the same cycle that pdm_clk_o toggles.
- channel_mode_i is sampled at the decision cycle; it may change at any time.
- channel_mode_i=00: clock runs and valid_o stays 0.
- Stereo mode: valid strobes alternate 0,1,0,1 per channel, spaced half cycles apart.
- WAKEUP/RUN boundary: the rising edge that completes the startup count does not produce a left sample. The first valid sample in stereo mode is the following right sample.
- channel_o and pdm_o hold their last values while valid_o=0.

Decomposition:
- pdm2pcm_pkg gets:
  - typedef enum logic [1:0] {IDLE, WAKEUP, RUN} pdm_frontend_state_t;
  - typedef struct packed {logic right, left;} pdm_channel_mode_t;
  - localparam PDM_MIN_HALF_PERIOD = 4.
- Sub-module pdm2pcm_clock_generator contains the half-period counter, divisor latch and clamp, and pdm_clk_o. It outputs pre-edge strobes pre_rise_o and pre_fall_o.
- The top level contains the synchronizer, FSM, startup counter ($clog2(STARTUP_EDGES+1) bits) and sample registers.

Test Plan:
- Reset in IDLE: rst_n_i low, then high with clk_en_i=0 for 50 cycles -> all outputs 0 and pdm_clk_o flat.
- Clocking and startup: clk_en_i=1, divisor=10, STARTUP_EDGES=4 -> pdm_clk_o period 20 cycles, 50% duty. running_o rises on the 4th rising edge. No valid_o before the first right sample after it.
- Stereo capture: mode=11, pdm_data_i driven 1 during low phases and 0 during high phases -> valid_o every 10 cycles. Channel alternates; the right sample is preceded by its left sample, except the first. Left samples are pdm_o=1, right samples are pdm_o=0.
- Mono modes and clamp: mode=01 with divisor=2 -> half=4, period 8. Only channel_o=0 strobes, every 8 cycles. mode=10 -> only channel_o=1 strobes. mode=00 -> none.
- Mid-stream divisor change: switch 10->6 while the counter is at 3 -> the current half-period completes at 10 cycles and subsequent half-periods are 6.
- Disable/reset mid-run: drop clk_en_i in RUN -> next cycle pdm_clk_o=0, valid_o=0, state IDLE, and re-enable repeats WAKEUP. Assert rst_n_i asynchronously mid-half-period -> outputs clear immediately without waiting for a clk_i edge.
